// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD event counter and its 7-segment display.
// Segment codes are active low in {g,f,e,d,c,b,a} order.
package bcd_disp_pkg;

    // Default build parameters for the display block
    localparam int DIGITS_DEF = 4;
    localparam int SCAN_W_DEF = 16;

    // Active-low segment patterns for decimal digits and the blank glyph
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 cannot occur in a BCD counter and are shown as blank.
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Map one BCD digit to its segment pattern, blanking illegal codes
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_event_display.sv
// Counts rising edges of the upstream FSM's cnt level in a DIGITS-wide BCD
// counter and drives a time-multiplexed common-anode 7-segment display.
// Optional feature macro: BCD_LZB_EN enables leading-zero blanking.
module bcd_event_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int SCAN_W = SCAN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   value,
    output logic                  ovf,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                r_cntQ;
    logic [4*DIGITS-1:0] r_value;
    logic                r_ovf;
    logic [SCAN_W-1:0]   r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;

    logic                w_evt;
    logic [4*DIGITS-1:0] w_nextValue;
    logic                w_carryOut;
    logic [3:0]          w_digit;
    logic [6:0]          w_segDec;
    logic                w_blank;

    assign w_evt = cnt & ~r_cntQ;

    // Delay cnt by one cycle; reset to 1 so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cntQ <= 1'b1;
        end else begin
            r_cntQ <= cnt;
        end
    end

    // Ripple an increment through the BCD digits, 9 rolling to 0 with carry
    always_comb begin
        logic carry;
        w_nextValue = r_value;
        carry       = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (r_value[4*k +: 4] == 4'd9) begin
                    w_nextValue[4*k +: 4] = 4'd0;
                end else begin
                    w_nextValue[4*k +: 4] = r_value[4*k +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
        w_carryOut = carry;
    end

    // Count register: clear beats an event, and a wrap pulses ovf for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else if (w_evt) begin
            r_value <= w_nextValue;
            r_ovf   <= w_carryOut;
        end else begin
            r_ovf   <= 1'b0;
        end
    end

    // Free-running prescaler; the digit index steps once per full prescaler period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (&r_pre) begin
                if (r_idx == IDX_W'(DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Select the digit currently being scanned out of the count register
    always_comb begin
        w_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit = r_value[4*k +: 4];
            end
        end
    end

    bcd_seg_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_segDec)
    );

`ifdef BCD_LZB_EN
    logic [DIGITS-1:0] w_upperZero;

    // A non-zero position is blanked when it and every more significant digit are zero
    always_comb begin
        w_upperZero             = '0;
        w_upperZero[DIGITS-1]   = (r_value[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            w_upperZero[k] = w_upperZero[k+1] && (r_value[4*k +: 4] == 4'd0);
        end
        w_blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_blank = w_upperZero[k];
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Register anode enable and segment pattern for the currently scanned digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(DIGITS'(1) << r_idx);
            r_seg <= w_blank ? SEG_BLANK : w_segDec;
        end
    end

    assign value = r_value;
    assign ovf   = r_ovf;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule

// File: tb/tb_bcd_event_display.sv
// Directed self-checking bench for bcd_event_display with DIGITS=4, SCAN_W=2.
// Honours BCD_LZB_EN when the macro is defined for the build.
module tb_bcd_event_display;

    logic        clk;
    logic        rst;
    logic        cnt;
    logic        clr;
    logic [15:0] value;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checkCount;
    int passCount;

    bcd_event_display #(
        .DIGITS (4),
        .SCAN_W (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cnt   (cnt),
        .clr   (clr),
        .value (value),
        .ovf   (ovf),
        .an    (an),
        .seg   (seg)
    );

    // Free-running 100 MHz style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle high pulse on cnt followed by one low cycle
    task automatic sendPulses(input int n);
        for (int i = 0; i < n; i++) begin
            cnt = 1'b1;
            tick();
            cnt = 1'b0;
            tick();
        end
    endtask

    // One-cycle clear of the count
    task automatic doClear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Step until the first cycle of the digit-0 slot; reports whether it was found
    task automatic alignScan(output bit ok);
        bit seen3;
        ok    = 1'b0;
        seen3 = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (an == 4'b0111) seen3 = 1'b1;
            else if (seen3 && an == 4'b1110) ok = 1'b1;
            if (!ok) tick();
        end
    endtask

    // Reset values, release with cnt high, and first display slot
    task automatic test_reset();
        rst = 1'b1;
        cnt = 1'b1;
        clr = 1'b0;
        repeat (3) tick();
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL reset_value got %h expected %h", value, 16'h0000);
        else passCount++;
        checkCount++;
        if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf got %b expected %b", ovf, 1'b0);
        else passCount++;
        checkCount++;
        if (seg !== 7'h7F) $display("[TB] FAIL reset_seg got %h expected %h", seg, 7'h7F);
        else passCount++;
        rst = 1'b0;
        checkCount++;
        if (an !== 4'b1111) $display("[TB] FAIL release_an got %b expected %b", an, 4'b1111);
        else passCount++;
        tick();
        checkCount++;
        if (an !== 4'b1110) $display("[TB] FAIL first_an got %b expected %b", an, 4'b1110);
        else passCount++;
        checkCount++;
        if (seg !== 7'h40) $display("[TB] FAIL first_seg got %h expected %h", seg, 7'h40);
        else passCount++;
        repeat (3) tick();
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL held_high_no_count got %h expected %h", value, 16'h0000);
        else passCount++;
        cnt = 1'b0;
        tick();
    endtask

    // Twelve separated pulses, including the 9 -> 10 carry
    task automatic test_pulses();
        sendPulses(9);
        checkCount++;
        if (value !== 16'h0009) $display("[TB] FAIL pulse9 got %h expected %h", value, 16'h0009);
        else passCount++;
        sendPulses(1);
        checkCount++;
        if (value !== 16'h0010) $display("[TB] FAIL pulse10_carry got %h expected %h", value, 16'h0010);
        else passCount++;
        sendPulses(2);
        checkCount++;
        if (value !== 16'h0012) $display("[TB] FAIL pulse12 got %h expected %h", value, 16'h0012);
        else passCount++;
        checkCount++;
        if (ovf !== 1'b0) $display("[TB] FAIL pulse_ovf got %b expected %b", ovf, 1'b0);
        else passCount++;
    endtask

    // Long high level counts once; fast toggling counts every second cycle
    task automatic test_hold_toggle();
        cnt = 1'b1;
        tick();
        checkCount++;
        if (value !== 16'h0013) $display("[TB] FAIL hold_latency got %h expected %h", value, 16'h0013);
        else passCount++;
        repeat (9) tick();
        cnt = 1'b0;
        tick();
        checkCount++;
        if (value !== 16'h0013) $display("[TB] FAIL hold_once got %h expected %h", value, 16'h0013);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            cnt = ~cnt;
            tick();
        end
        cnt = 1'b0;
        tick();
        checkCount++;
        if (value !== 16'h0015) $display("[TB] FAIL toggle got %h expected %h", value, 16'h0015);
        else passCount++;
    endtask

    // Full wrap from 9999 to 0000 with a single-cycle ovf pulse
    task automatic test_wrap();
        doClear();
        tick();
        sendPulses(9999);
        checkCount++;
        if (value !== 16'h9999) $display("[TB] FAIL wrap_9999 got %h expected %h", value, 16'h9999);
        else passCount++;
        checkCount++;
        if (ovf !== 1'b0) $display("[TB] FAIL wrap_pre_ovf got %b expected %b", ovf, 1'b0);
        else passCount++;
        cnt = 1'b1;
        tick();
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL wrap_zero got %h expected %h", value, 16'h0000);
        else passCount++;
        checkCount++;
        if (ovf !== 1'b1) $display("[TB] FAIL wrap_ovf got %b expected %b", ovf, 1'b1);
        else passCount++;
        cnt = 1'b0;
        tick();
        checkCount++;
        if (ovf !== 1'b0) $display("[TB] FAIL wrap_ovf_drop got %b expected %b", ovf, 1'b0);
        else passCount++;
    endtask

    // Clear and a rising edge in the same cycle: clear wins and the event is lost
    task automatic test_clr_evt();
        sendPulses(5);
        checkCount++;
        if (value !== 16'h0005) $display("[TB] FAIL clr_setup got %h expected %h", value, 16'h0005);
        else passCount++;
        cnt = 1'b1;
        clr = 1'b1;
        tick();
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL clr_evt_value got %h expected %h", value, 16'h0000);
        else passCount++;
        checkCount++;
        if (ovf !== 1'b0) $display("[TB] FAIL clr_evt_ovf got %b expected %b", ovf, 1'b0);
        else passCount++;
        clr = 1'b0;
        tick();
        cnt = 1'b0;
        tick();
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL clr_evt_dropped got %h expected %h", value, 16'h0000);
        else passCount++;
    endtask

    // Scan 1234 across all four positions, four cycles per slot
    task automatic test_scan();
        bit         ok;
        logic [6:0] segExp [4];
        segExp = '{7'h19, 7'h30, 7'h24, 7'h79};
        doClear();
        tick();
        sendPulses(1234);
        checkCount++;
        if (value !== 16'h1234) $display("[TB] FAIL scan_setup got %h expected %h", value, 16'h1234);
        else passCount++;
        alignScan(ok);
        checkCount++;
        if (!ok) $display("[TB] FAIL scan_align got %b expected %b", ok, 1'b1);
        else passCount++;
        for (int i = 0; i < 16; i++) begin
            checkCount++;
            if (an !== ~(4'b0001 << (i / 4)))
                $display("[TB] FAIL scan_an[%0d] got %b expected %b", i, an, ~(4'b0001 << (i / 4)));
            else passCount++;
            checkCount++;
            if (seg !== segExp[i / 4])
                $display("[TB] FAIL scan_seg[%0d] got %h expected %h", i, seg, segExp[i / 4]);
            else passCount++;
            tick();
        end
    endtask

    // Value 0042: upper slots show zeros, or blank when leading-zero blanking is built in
    task automatic test_lzb();
        bit         ok;
        logic [6:0] segExp [4];
`ifdef BCD_LZB_EN
        segExp = '{7'h24, 7'h19, 7'h7F, 7'h7F};
`else
        segExp = '{7'h24, 7'h19, 7'h40, 7'h40};
`endif
        doClear();
        tick();
        sendPulses(42);
        checkCount++;
        if (value !== 16'h0042) $display("[TB] FAIL lzb_setup got %h expected %h", value, 16'h0042);
        else passCount++;
        alignScan(ok);
        checkCount++;
        if (!ok) $display("[TB] FAIL lzb_align got %b expected %b", ok, 1'b1);
        else passCount++;
        for (int i = 0; i < 16; i++) begin
            checkCount++;
            if (seg !== segExp[i / 4])
                $display("[TB] FAIL lzb_seg[%0d] got %h expected %h", i, seg, segExp[i / 4]);
            else passCount++;
            tick();
        end
    endtask

    // Run every scenario in order and report
    initial begin
        checkCount = 0;
        passCount  = 0;
        rst = 1'b1;
        cnt = 1'b0;
        clr = 1'b0;
        test_reset();
        test_pulses();
        test_hold_toggle();
        test_wrap();
        test_clr_evt();
        test_scan();
        test_lzb();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
